// File: rtl/word_packer_pkg.sv
// Shared widths, FIFO entry type and byte-lane placement for word_packer.
// Lane order follows WORD_P​ACKER_BSWAP_EN: defined = big-endian, undefined = little-endian.
package word_packer_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

  // Returns the byte shifted into the lane selected by its position in the word.
  function automatic logic [WORD_W-1:0] place_byte(input logic [BYTE_W-1:0] b,
                                                  input logic [IDX_W-1:0]  idx);
    logic [IDX_W-1:0] lane;
`ifdef WORD_PACKER_BSWAP_EN
    lane = ~idx;
`else
    lane = idx;
`endif
    return {{(WORD_W-BYTE_W){1'b0}}, b} << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/word_packer_fifo.sv
// Register-based synchronous FIFO with show-ahead head output.
// Push is ignored when full and pop when empty; full/empty come from a registered count.
module word_packer_fifo
  import word_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t wdata,
  output fifo_entry_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fifo_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word_packer.sv
// Packs a byte stream into 32-bit words, zero-padding the final word of each packet,
// and feeds them downstream through a small FIFO. Endianness set by WORD_PACKER_BSWAP_EN.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_vld,
  input  logic              byte_last,
  output logic              byte_rdy,
  output logic [WORD_W-1:0] dout,
  output logic              wen,
  input  logic              rdy,
  output logic              pkt_done
);

  // Handshakes: a byte moves on an edge with byte_vld && byte_rdy; a word moves on an
  // edge with wen && rdy. dout/wen hold steady until the word is taken.

  logic [WORD_W-1:0] acc;
  logic [IDX_W-1:0]  idx;
  logic              rst_done;
  logic              byte_acc;
  logic              push_word;
  logic              pop_word;
  logic [WORD_W-1:0] word_next;
  logic              fifo_full;
  logic              fifo_empty;
  fifo_entry_t       fifo_wdata;
  fifo_entry_t       fifo_head;

  assign byte_rdy   = rst_done && !fifo_full;
  assign byte_acc   = byte_vld && byte_rdy;
  assign word_next  = acc | place_byte(byte_in, idx);
  assign push_word  = byte_acc && (byte_last || idx == IDX_W'(BYTES_PER_WORD-1));
  assign fifo_wdata = '{last: byte_last, data: word_next};
  assign wen        = !fifo_empty;
  assign pop_word   = wen && rdy;
  assign dout       = fifo_head.data;

  word_packer_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_word),
    .pop   (pop_word),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Accumulator clears on every push so unfilled lanes of a short word stay zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      idx      <= '0;
      rst_done <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      pkt_done <= pop_word && fifo_head.last;
      if (byte_acc) begin
        if (push_word) begin
          acc <= '0;
          idx <= '0;
        end else begin
          acc <= word_next;
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule
